// File: rtl/seq_mul_nbit.sv
// Sequential shift-and-add unsigned multiplier, N x N -> 2N, one product per N+1 cycles.
// Optional SEQ_MUL_EARLY_DONE_EN ends the iteration once the remaining multiplier bits are all zero.
module seq_mul_nbit #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [1:0]     dbg_state
);

    // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE);
    // busy stays high for the whole iteration; done pulses for one cycle with q valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [2*N-1:0]  r_amem;
    logic [N-1:0]    r_bmem;
    logic [2*N-1:0]  r_acc;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;
    logic [2*N-1:0]  r_q;

    logic [2*N-1:0]  w_addend;
    logic [2*N-1:0]  w_sum;
    logic            w_last;

    assign w_addend = r_bmem[0] ? r_amem : '0;
    assign w_sum    = r_acc + w_addend;

`ifdef SEQ_MUL_EARLY_DONE_EN
    assign w_last = (r_count == CW'(1)) || ((r_bmem >> 1) == '0);
`else
    assign w_last = (r_count == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_amem  <= '0;
            r_bmem  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_amem  <= {{N{1'b0}}, a};
                        r_bmem  <= b;
                        r_acc   <= '0;
                        r_count <= CW'(N);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_sum;
                    r_amem  <= r_amem << 1;
                    r_bmem  <= r_bmem >> 1;
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        // The final addend is folded in here so q is ready with done.
                        r_q     <= w_sum;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_amem  <= {{N{1'b0}}, a};
                        r_bmem  <= b;
                        r_acc   <= '0;
                        r_count <= CW'(N);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign q         = r_q;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mul_nbit.sv
// Self-checking bench for seq_mul_nbit (N=8): directed cases plus random operands against a
// plain-arithmetic product/iteration model; works with or without SEQ_MUL_EARLY_DONE_EN.
module tb_seq_mul_nbit;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] q;
    logic [1:0]     dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [2*N-1:0] exp_q[$];

    seq_mul_nbit #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: number of iterations an operation should take
    function automatic int exp_iters(input logic [N-1:0] bv);
`ifdef SEQ_MUL_EARLY_DONE_EN
        int h;
        h = 0;
        for (int i = 0; i < N; i++) if (bv[i]) h = i + 1;
        return (h == 0) ? 1 : h;
`else
        return N;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2*N-1:0] pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    // driver: one isolated operation, checked for latency, busy shape, q hold and result
    task automatic do_op(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib);
        int n;
        int busy_bad;
        int q_moved;
        logic [2*N-1:0] q_before;
        exp_q.push_back((2*N)'(ia) * (2*N)'(ib));
        @(negedge clk);
        q_before = q;
        start = 1'b1; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = N'($urandom); b = N'($urandom);
        n = 0; busy_bad = 0; q_moved = 0;
        while (!done && n < 40) begin
            if (!busy) busy_bad++;
            if (q !== q_before) q_moved++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_iters(ib));
        chk({tag, "_busy_gaps"}, busy_bad, 0);
        chk({tag, "_q_hold"}, q_moved, 0);
        chk({tag, "_q"}, q, pop_exp());
        chk({tag, "_busy_in_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int gap;
        int extra;
        start = 1'b0; a = '0; b = '0;
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        #16 rst = 1'b1;

        // directed
        do_op("ff_x_ff", 8'd255, 8'd255);
        chk("ff_x_ff_value", q, 16'hFE01);
        do_op("a0", 8'd0, 8'd173);
        do_op("b0", 8'd200, 8'd0);
        do_op("one", 8'd9, 8'd1);
        do_op("msb", 8'd9, 8'h80);
        do_op("b_zero_early", 8'd9, 8'd0);

        // back-to-back: start held high, second operands presented in the DONE cycle
        exp_q.push_back(16'd15);
        exp_q.push_back(16'd120);
        @(negedge clk);
        start = 1'b1; a = 8'd3; b = 8'd5;
        @(negedge clk);
        a = 8'd12; b = 8'd10;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("b2b_first_latency", n, exp_iters(8'd5));
        chk("b2b_first_q", q, pop_exp());
        gap = 0;
        do begin @(negedge clk); gap++; end while (!done && gap < 40);
        start = 1'b0;
        chk("b2b_gap", gap, exp_iters(8'd10) + 1);
        chk("b2b_second_q", q, pop_exp());

        // start while busy is ignored
        repeat (2) @(negedge clk);
        exp_q.push_back(16'd24);
        start = 1'b1; a = 8'd6; b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) begin start = 1'b1; a = 8'd7; b = 8'd9; end
            else start = 1'b0;
        end
        start = 1'b0;
        chk("ignore_latency", n, exp_iters(8'd4));
        chk("ignore_q", q, pop_exp());
        extra = 0;
        repeat (12) begin @(negedge clk); if (done || busy) extra++; end
        chk("ignore_no_second_op", extra, 0);
        chk("ignore_q_held", q, 16'd24);

        // asynchronous abort in the middle of an operation
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", q, 0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (3) begin @(negedge clk); if (done) extra++; end
        chk("abort_no_done", extra, 0);
        do_op("after_abort", 8'd2, 8'd3);

        // random operands, with occasional boundary values
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom_range(0, 255));
            rb = N'($urandom_range(0, 255));
            if (i % 7 == 3) rb = 8'd0;
            if (i % 5 == 1) ra = 8'd255;
            do_op("rand", ra, rb);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
